pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter NUM_SRC, default 2, source operands checked per ID instruction.
REQ-003 Parameter FWD_STAGES, default 3, downstream stages eligible for forwarding (1=EX, 2=MEM, 3=WB).
REQ-004 Parameter BR_LAT, default 1, cycles from branch entering EX to resolution, range 1-4.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 id_opcode  input  6  opcode of the instruction in ID, ISA encoding.
REQ-008 id_valid  input  1  ID holds a real instruction.
REQ-009 id_src  input  NUM_SRC*REG_AW  source register fields of the ID instruction.
REQ-010 stg_rd  input  FWD_STAGES*REG_AW  destination register per downstream stage, index 0 = EX.
REQ-011 stg_wr  input  FWD_STAGES  register-write valid per downstream stage.
REQ-012 ex_is_load  input  1  EX stage holds LD.
REQ-013 br_resolved  input  1  EX branch outcome valid this cycle.
REQ-014 br_taken  input  1  outcome; qualified by br_resolved.
REQ-015 mem_busy  input  2  00 idle, 01 CPU, 10 SPART, 11 Audio.
REQ-016 stall  output  1  hold PC and IF/ID.
REQ-017 flush  output  1  squash IF/ID and ID/EX.
REQ-018 pc_mode  output  2  00 PC+4, 01 branch target, 10 JI, 11 JR.
REQ-019 fwd_sel  output  NUM_SRC*$clog2(FWD_STAGES+1)  per-source select: 0 regfile, k = stage k.
REQ-020 hz_state  output  3  current FSM state, for debug.

Function
REQ-021 FSM states SHALL be RUN, LD_USE, BR_WAIT, MEM_WAIT, FLUSH.
REQ-022 RUN->LD_USE when id_valid, ex_is_load, stg_wr[0], and any nonzero id_src equals stg_rd[0]; LD_USE asserts stall for exactly one cycle, then returns to RUN.
REQ-023 RUN->BR_WAIT when id_valid and id_opcode is BEQ or BNE; stall asserted in BR_WAIT; an internal counter loads BR_LAT and decrements each cycle.
REQ-024 In BR_WAIT, br_resolved with br_taken -> FLUSH with pc_mode=01 that cycle; br_resolved without br_taken -> RUN with pc_mode=00.
REQ-025 FLUSH SHALL assert flush for one cycle, stall deasserted, then RUN.
REQ-026 If the BR_WAIT counter reaches 0 without br_resolved, FSM SHALL hold BR_WAIT and stall until br_resolved (no timeout).
REQ-027 JI SHALL drive pc_mode=10 and JR pc_mode=11 in the ID cycle, with flush for one cycle; no stall.
REQ-028 RUN->MEM_WAIT when id_opcode is LD or ST and mem_busy is 10 or 11; stall held until mem_busy is 00 or 01, then RUN next cycle.
REQ-029 Priority on simultaneous conditions: BR_WAIT resolution > MEM_WAIT > LD_USE > new branch.
REQ-030 fwd_sel per source SHALL be combinational: lowest-index stage k with stg_wr set and matching stg_rd; register 0 never forwarded; no match gives 0.
REQ-031 fwd_sel SHALL be 0 while stall is asserted.
REQ-032 pc_mode SHALL be 00 in every case not listed above.
REQ-033 id_valid low SHALL suppress all new hazard detection.

Reset
REQ-034 On rst_n low at a clock edge: FSM=RUN, counter=0, stall=0, flush=0, pc_mode=00, fwd_sel=0.
REQ-035 Reset during BR_WAIT or MEM_WAIT SHALL abandon the pending operation with no flush.

Structure
REQ-036 Opcode constants, FSM state enum, and pc_mode/mem_busy encodings SHALL live in shared package cpu_pkg.
REQ-037 Forwarding comparison SHALL be a sub-module fwd_match, instantiated once per source via generate.

Verification
REQ-038 LD r3 in EX, ID uses r3 -> stall=1 for one cycle, then fwd_sel=1 for that source.
REQ-039 BEQ in ID, BR_LAT=2, br_resolved=1 and br_taken=1 on cycle 2 -> stall cycles 0-1, pc_mode=01, flush=1 for one cycle.
REQ-040 BNE not taken -> stall until resolve, pc_mode=00, flush never asserts.
REQ-041 ST in ID with mem_busy=10 for 4 cycles -> stall=1 for 4 cycles, RUN on cycle 5.
REQ-042 r5 written by stages 1 and 3, ID src=r5 -> fwd_sel=1; src=r0 -> fwd_sel=0.
REQ-043 rst_n low mid-BR_WAIT -> next cycle FSM=RUN, stall=0, flush=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the pipeline control logic.
//   - Opcode constants for the instructions that the hazard unit inspects.
//   - Hazard FSM state enumeration (also exported on hz_state for debug).
//   - pc_mode and mem_busy encodings.
//   - Small classification helpers used by the hazard controller.
// -----------------------------------------------------------------------------
package cpu_pkg;

  // Opcodes of interest. Everything else is treated as an ordinary ALU op.
  localparam logic [5:0] OP_JI  = 6'b000010;
  localparam logic [5:0] OP_JR  = 6'b000011;
  localparam logic [5:0] OP_BEQ = 6'b001000;
  localparam logic [5:0] OP_BNE = 6'b001001;
  localparam logic [5:0] OP_LD  = 6'b010000;
  localparam logic [5:0] OP_ST  = 6'b010001;

  // Hazard FSM states.
  typedef enum logic [2:0] {
    RUN      = 3'd0,
    LD_USE   = 3'd1,
    BR_WAIT  = 3'd2,
    MEM_WAIT = 3'd3,
    FLUSH    = 3'd4
  } hz_state_e;

  // Next-PC source selection.
  localparam logic [1:0] PC_SEQ    = 2'b00;  // PC+4
  localparam logic [1:0] PC_BRANCH = 2'b01;  // branch target
  localparam logic [1:0] PC_JI     = 2'b10;  // immediate jump
  localparam logic [1:0] PC_JR     = 2'b11;  // register jump

  // Memory-port owner.
  localparam logic [1:0] MEM_IDLE  = 2'b00;
  localparam logic [1:0] MEM_CPU   = 2'b01;
  localparam logic [1:0] MEM_SPART = 2'b10;
  localparam logic [1:0] MEM_AUDIO = 2'b11;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BEQ) || (op == OP_BNE);
  endfunction

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LD) || (op == OP_ST);
  endfunction

  // The CPU only has to wait when a peripheral owns the memory port;
  // idle or CPU ownership both let a load/store proceed.
  function automatic logic mem_blocks_cpu(input logic [1:0] mb);
    return (mb == MEM_SPART) || (mb == MEM_AUDIO);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// -----------------------------------------------------------------------------
// fwd_match
// Forwarding source selection for one ID source operand.
// Picks the youngest (lowest index) downstream stage that writes the source
// register; register 0 is hard-wired and never forwarded.
//   src    : source register address of the ID instruction
//   stg_rd : destination register per downstream stage, index 0 = EX
//   stg_wr : register-write valid per downstream stage
//   sel    : 0 = register file, k = forward from stage k (1 = EX)
// -----------------------------------------------------------------------------
module fwd_match #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 3,
  parameter int SEL_W      = 2
) (
  input  logic [REG_AW-1:0]            src,
  input  logic [FWD_STAGES*REG_AW-1:0] stg_rd,
  input  logic [FWD_STAGES-1:0]        stg_wr,
  output logic [SEL_W-1:0]             sel
);

  logic [FWD_STAGES-1:0] hit;

  for (genvar gi = 0; gi < FWD_STAGES; gi++) begin : g_stage
    assign hit[gi] = stg_wr[gi] && (src != '0) &&
                     (stg_rd[gi*REG_AW +: REG_AW] == src);
  end

  // Scan oldest to youngest so the youngest match is the one left standing.
  always_comb begin
    sel = '0;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Hazard detection and forwarding control for a 5-stage pipeline.
//   clk, rst_n   : clock, synchronous active-low reset
//   id_opcode    : opcode of the instruction in ID
//   id_valid     : ID holds a real instruction
//   id_src       : NUM_SRC source register fields of the ID instruction
//   stg_rd       : destination register per downstream stage (index 0 = EX)
//   stg_wr       : register-write valid per downstream stage
//   ex_is_load   : EX stage holds a load
//   br_resolved  : branch outcome in EX valid this cycle
//   br_taken     : branch outcome (qualified by br_resolved)
//   mem_busy     : memory-port owner (idle / CPU / SPART / Audio)
//   stall        : hold PC and IF/ID
//   flush        : squash IF/ID and ID/EX
//   pc_mode      : next-PC source
//   fwd_sel      : per-source forwarding select (0 = regfile, k = stage k)
//   hz_state     : current FSM state, for debug
//
// A newly detected hazard raises stall combinationally in the cycle it is
// seen, so the offending instruction never leaves ID; the FSM then carries
// the stall for as long as the hazard lasts.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int FWD_STAGES = 3,
  parameter int BR_LAT     = 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [5:0]                                id_opcode,
  input  logic                                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0]                 id_src,
  input  logic [FWD_STAGES*REG_AW-1:0]              stg_rd,
  input  logic [FWD_STAGES-1:0]                     stg_wr,
  input  logic                                      ex_is_load,
  input  logic                                      br_resolved,
  input  logic                                      br_taken,
  input  logic [1:0]                                mem_busy,
  output logic                                      stall,
  output logic                                      flush,
  output logic [1:0]                                pc_mode,
  output logic [NUM_SRC*$clog2(FWD_STAGES+1)-1:0]   fwd_sel,
  output logic [2:0]                                hz_state
);

  localparam int SEL_W = $clog2(FWD_STAGES + 1);
  localparam int CNT_W = 3;  // holds BR_LAT up to 4

  hz_state_e        state_reg, state_next;
  logic [CNT_W-1:0] br_cnt_reg, br_cnt_next;

  logic [NUM_SRC-1:0]       ld_src_hit;
  logic [NUM_SRC*SEL_W-1:0] fwd_raw;

  // ---------------------------------------------------------------------------
  // Per-source operand checks: load-use compare against EX and the
  // forwarding selector.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [REG_AW-1:0] src_addr;

    assign src_addr       = id_src[gi*REG_AW +: REG_AW];
    assign ld_src_hit[gi] = (src_addr != '0) &&
                            (src_addr == stg_rd[REG_AW-1:0]);

    fwd_match #(
      .REG_AW    (REG_AW),
      .FWD_STAGES(FWD_STAGES),
      .SEL_W     (SEL_W)
    ) u_fwd_match (
      .src   (src_addr),
      .stg_rd(stg_rd),
      .stg_wr(stg_wr),
      .sel   (fwd_raw[gi*SEL_W +: SEL_W])
    );
  end

  // ---------------------------------------------------------------------------
  // Hazard conditions seen in ID. All of them require a real instruction.
  // ---------------------------------------------------------------------------
  logic load_use;
  logic mem_hazard;
  logic new_branch;
  logic is_ji;
  logic is_jr;

  assign load_use   = id_valid && ex_is_load && stg_wr[0] && (|ld_src_hit);
  assign mem_hazard = id_valid && is_mem_op(id_opcode) && mem_blocks_cpu(mem_busy);
  assign new_branch = id_valid && is_branch(id_opcode);
  assign is_ji      = id_valid && (id_opcode == OP_JI);
  assign is_jr      = id_valid && (id_opcode == OP_JR);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= RUN;
      br_cnt_reg <= '0;
    end else begin
      state_reg  <= state_next;
      br_cnt_reg <= br_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and raw outputs
  // ---------------------------------------------------------------------------
  logic       stall_c;
  logic       flush_c;
  logic [1:0] pc_c;

  always_comb begin
    state_next  = state_reg;
    br_cnt_next = br_cnt_reg;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    pc_c        = PC_SEQ;

    case (state_reg)
      // LD_USE is the one-cycle shadow after a load-use stall: the load has
      // moved past EX, so the same EX contents must not re-trigger the stall.
      // Other hazards of the (still waiting) ID instruction are still caught
      // here so that e.g. a branch fed by a load cannot slip through.
      RUN, LD_USE: begin
        state_next = RUN;
        if (mem_hazard) begin
          state_next = MEM_WAIT;
          stall_c    = 1'b1;
        end else if (load_use && (state_reg == RUN)) begin
          state_next = LD_USE;
          stall_c    = 1'b1;
        end else if (new_branch) begin
          state_next  = BR_WAIT;
          stall_c     = 1'b1;
          br_cnt_next = CNT_W'(BR_LAT);
        end else if (is_ji) begin
          flush_c = 1'b1;
          pc_c    = PC_JI;
        end else if (is_jr) begin
          flush_c = 1'b1;
          pc_c    = PC_JR;
        end
      end

      // The counter tracks the nominal resolution latency; a late outcome
      // simply keeps us here with the counter parked at zero.
      BR_WAIT: begin
        if (br_resolved) begin
          br_cnt_next = '0;
          if (br_taken) begin
            state_next = FLUSH;
            pc_c       = PC_BRANCH;
          end else begin
            state_next = RUN;
          end
        end else begin
          stall_c = 1'b1;
          if (br_cnt_reg != '0) br_cnt_next = br_cnt_reg - CNT_W'(1);
        end
      end

      MEM_WAIT: begin
        if (mem_blocks_cpu(mem_busy)) begin
          stall_c = 1'b1;
        end else begin
          state_next = RUN;
        end
      end

      FLUSH: begin
        flush_c    = 1'b1;
        state_next = RUN;
      end

      default: begin
        state_next  = RUN;
        br_cnt_next = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. While reset is applied nothing is requested from the pipeline,
  // so a pending branch or memory wait is abandoned without a flush.
  // ---------------------------------------------------------------------------
  assign stall    = rst_n && stall_c;
  assign flush    = rst_n && flush_c;
  assign pc_mode  = rst_n ? pc_c : PC_SEQ;
  assign fwd_sel  = (rst_n && !stall_c) ? fwd_raw : '0;
  assign hz_state = state_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
// Self-checking bench for pipe_hazard_ctrl (REG_AW=5, NUM_SRC=2,
// FWD_STAGES=3, BR_LAT=2): a table of single-cycle vectors, hand-written
// multi-cycle sequences, and a randomized run against a reference model.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  import cpu_pkg::*;

  localparam int AW  = 5;
  localparam int NS  = 2;
  localparam int FS  = 3;
  localparam int BRL = 2;
  localparam logic [5:0] OP_ADD = 6'h20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic [5:0]    id_opcode;
  logic          id_valid;
  logic [9:0]    id_src;
  logic [14:0]   stg_rd;
  logic [2:0]    stg_wr;
  logic          ex_is_load;
  logic          br_resolved;
  logic          br_taken;
  logic [1:0]    mem_busy;
  logic          stall;
  logic          flush;
  logic [1:0]    pc_mode;
  logic [3:0]    fwd_sel;
  logic [2:0]    hz_state;

  pipe_hazard_ctrl #(
    .REG_AW(AW), .NUM_SRC(NS), .FWD_STAGES(FS), .BR_LAT(BRL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_valid(id_valid),
    .id_src(id_src), .stg_rd(stg_rd), .stg_wr(stg_wr), .ex_is_load(ex_is_load),
    .br_resolved(br_resolved), .br_taken(br_taken), .mem_busy(mem_busy),
    .stall(stall), .flush(flush), .pc_mode(pc_mode), .fwd_sel(fwd_sel),
    .hz_state(hz_state)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int want);
    n_total++;
    if (act == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, want);
  endtask

  task automatic chk_out(input string tag, input int es, input int ef,
                         input int ep, input int efw, input int est);
    chk({tag, ".stall"},    int'(stall),    es);
    chk({tag, ".flush"},    int'(flush),    ef);
    chk({tag, ".pc_mode"},  int'(pc_mode),  ep);
    chk({tag, ".fwd_sel"},  int'(fwd_sel),  efw);
    chk({tag, ".hz_state"}, int'(hz_state), est);
  endtask

  function automatic logic [9:0] srcs(input int s0, input int s1);
    return {5'(s1), 5'(s0)};
  endfunction

  function automatic logic [14:0] rds(input int ex, input int mem, input int wb);
    return {5'(wb), 5'(mem), 5'(ex)};
  endfunction

  task automatic idle_inputs();
    id_opcode = OP_ADD; id_valid = 1'b0; id_src = '0; stg_rd = '0; stg_wr = '0;
    ex_is_load = 1'b0; br_resolved = 1'b0; br_taken = 1'b0; mem_busy = MEM_IDLE;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Single-cycle vector table (every vector leaves the FSM in RUN)
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [5:0]  op;
    logic        vld;
    logic [9:0]  src;
    logic [14:0] rd;
    logic [2:0]  wr;
    logic        ld;
    logic [1:0]  mb;
    int          e_flush;
    int          e_pc;
    int          e_fwd;   // {sel1, sel0}
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [5:0] op, input logic vld, input logic [9:0] src,
                         input logic [14:0] rd, input logic [2:0] wr, input logic ld,
                         input logic [1:0] mb, input int ef, input int ep,
                         input int fw0, input int fw1);
    vec_t v;
    v.op = op; v.vld = vld; v.src = src; v.rd = rd; v.wr = wr; v.ld = ld; v.mb = mb;
    v.e_flush = ef; v.e_pc = ep; v.e_fwd = fw1 * 4 + fw0;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: pending-condition flags rather than an encoded state.
  // ---------------------------------------------------------------------------
  bit m_br, m_mem, m_fl, m_ld;      // waiting on branch / memory, flush due, load shadow
  bit n_br, n_mem, n_fl, n_ld;
  int e_stall, e_flush, e_pc, e_fwd, e_state;

  function automatic int ref_fwd(input logic [4:0] s);
    for (int k = 0; k < FS; k++) begin
      if (s != 0 && stg_wr[k] && stg_rd[k*AW +: AW] == s) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_eval();
    bit blocked, ld_hit, is_br, is_mem;
    logic [4:0] s0, s1, rd0;
    s0 = id_src[4:0];
    s1 = id_src[9:5];
    rd0 = stg_rd[4:0];
    blocked = (mem_busy == MEM_SPART) || (mem_busy == MEM_AUDIO);
    ld_hit  = ex_is_load && stg_wr[0] && ((s0 != 0 && s0 == rd0) || (s1 != 0 && s1 == rd0));
    is_br   = (id_opcode == OP_BEQ) || (id_opcode == OP_BNE);
    is_mem  = (id_opcode == OP_LD) || (id_opcode == OP_ST);

    e_state = m_fl ? int'(FLUSH) : m_br ? int'(BR_WAIT) : m_mem ? int'(MEM_WAIT) :
              m_ld ? int'(LD_USE) : int'(RUN);
    e_stall = 0; e_flush = 0; e_pc = 0;
    n_br = 0; n_mem = 0; n_fl = 0; n_ld = 0;

    if (m_fl) begin
      e_flush = 1;
    end else if (m_br) begin
      if (br_resolved) begin
        e_pc = br_taken ? 1 : 0;
        n_fl = br_taken;
      end else begin
        e_stall = 1; n_br = 1;
      end
    end else if (m_mem) begin
      if (blocked) begin e_stall = 1; n_mem = 1; end
    end else if (id_valid) begin
      if (is_mem && blocked)        begin e_stall = 1; n_mem = 1; end
      else if (ld_hit && !m_ld)     begin e_stall = 1; n_ld = 1; end
      else if (is_br)               begin e_stall = 1; n_br = 1; end
      else if (id_opcode == OP_JI)  begin e_flush = 1; e_pc = 2; end
      else if (id_opcode == OP_JR)  begin e_flush = 1; e_pc = 3; end
    end

    e_fwd = (e_stall != 0) ? 0 : ref_fwd(s1) * 4 + ref_fwd(s0);

    if (!rst_n) begin
      e_stall = 0; e_flush = 0; e_pc = 0; e_fwd = 0;
      n_br = 0; n_mem = 0; n_fl = 0; n_ld = 0;
    end
  endtask

  task automatic model_commit();
    m_br = n_br; m_mem = n_mem; m_fl = n_fl; m_ld = n_ld;
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();

    // Reset with a branch presented: nothing may be requested.
    id_valid = 1'b1; id_opcode = OP_BEQ;
    settle();
    chk_out("reset_active", 0, 0, 0, 0, int'(hz_state) == int'(BR_WAIT) ? -1 : int'(hz_state));
    tick();
    tick();
    rst_n = 1'b1;
    idle_inputs();
    settle();
    $display("reset: stall=%0d flush=%0d pc=%0d fwd=%0d st=%0d", stall, flush, pc_mode, fwd_sel, hz_state);
    chk_out("reset_state", 0, 0, 0, 0, int'(RUN));
    tick();

    // ---- table-driven vectors ----
    add_vec(OP_ADD, 1, srcs(5, 0),  rds(5, 7, 5),  3'b111, 0, MEM_IDLE,  0, 0, 1, 0);
    add_vec(OP_ADD, 1, srcs(5, 9),  rds(1, 9, 5),  3'b111, 0, MEM_IDLE,  0, 0, 3, 2);
    add_vec(OP_ADD, 1, srcs(5, 5),  rds(5, 2, 5),  3'b110, 0, MEM_IDLE,  0, 0, 3, 3);
    add_vec(OP_ADD, 1, srcs(0, 0),  rds(0, 0, 0),  3'b111, 0, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_JI,  1, srcs(3, 4),  rds(4, 0, 0),  3'b001, 0, MEM_IDLE,  1, 2, 0, 1);
    add_vec(OP_JR,  1, srcs(6, 0),  rds(0, 6, 0),  3'b010, 0, MEM_IDLE,  1, 3, 2, 0);
    add_vec(OP_BEQ, 0, srcs(1, 0),  rds(0, 0, 0),  3'b000, 0, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_JI,  0, srcs(0, 0),  rds(0, 0, 0),  3'b000, 0, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_ADD, 1, srcs(0, 0),  rds(0, 0, 0),  3'b001, 1, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_ADD, 1, srcs(4, 0),  rds(4, 0, 0),  3'b000, 1, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_LD,  1, srcs(2, 0),  rds(0, 0, 0),  3'b000, 0, MEM_CPU,   0, 0, 0, 0);
    add_vec(OP_ST,  1, srcs(9, 10), rds(8, 0, 0),  3'b001, 1, MEM_IDLE,  0, 0, 0, 0);
    add_vec(OP_LD,  0, srcs(0, 0),  rds(0, 0, 0),  3'b000, 0, MEM_SPART, 0, 0, 0, 0);
    add_vec(OP_ADD, 0, srcs(3, 0),  rds(3, 0, 0),  3'b001, 1, MEM_IDLE,  0, 0, 1, 0);

    foreach (vecs[i]) begin
      id_opcode = vecs[i].op; id_valid = vecs[i].vld; id_src = vecs[i].src;
      stg_rd = vecs[i].rd; stg_wr = vecs[i].wr; ex_is_load = vecs[i].ld;
      mem_busy = vecs[i].mb; br_resolved = 1'b0; br_taken = 1'b0;
      settle();
      $display("vec %0d: op=%h vld=%0d stall=%0d flush=%0d pc=%0d fwd=%h",
               i, id_opcode, id_valid, stall, flush, pc_mode, fwd_sel);
      chk_out($sformatf("vec%0d", i), 0, vecs[i].e_flush, vecs[i].e_pc, vecs[i].e_fwd, int'(RUN));
      tick();
    end
    idle_inputs();
    tick();

    // ---- load-use: LD r3 in EX, ID reads r3 ----
    id_valid = 1; id_opcode = OP_ADD; id_src = srcs(3, 0);
    stg_rd = rds(3, 0, 0); stg_wr = 3'b001; ex_is_load = 1;
    settle();
    $display("ld_use c0: stall=%0d fwd=%h st=%0d", stall, fwd_sel, hz_state);
    chk("ld_use.c0.stall", int'(stall), 1);
    chk("ld_use.c0.fwd",   int'(fwd_sel), 0);
    tick();
    settle();
    $display("ld_use c1: stall=%0d fwd=%h st=%0d", stall, fwd_sel, hz_state);
    chk("ld_use.c1.stall", int'(stall), 0);
    chk("ld_use.c1.fwd",   int'(fwd_sel), 1);
    chk("ld_use.c1.state", int'(hz_state), int'(LD_USE));
    tick();
    id_valid = 0;
    settle();
    chk("ld_use.c2.state", int'(hz_state), int'(RUN));
    chk("ld_use.c2.stall", int'(stall), 0);
    idle_inputs();
    tick();

    // ---- BEQ taken, resolved on cycle 2 ----
    id_valid = 1; id_opcode = OP_BEQ; id_src = srcs(1, 2);
    for (int c = 0; c < 2; c++) begin
      settle();
      $display("beq c%0d: stall=%0d pc=%0d flush=%0d st=%0d", c, stall, pc_mode, flush, hz_state);
      chk($sformatf("beq.c%0d.stall", c), int'(stall), 1);
      chk($sformatf("beq.c%0d.flush", c), int'(flush), 0);
      chk($sformatf("beq.c%0d.pc", c), int'(pc_mode), 0);
      tick();
    end
    br_resolved = 1; br_taken = 1;
    settle();
    $display("beq c2: stall=%0d pc=%0d flush=%0d st=%0d", stall, pc_mode, flush, hz_state);
    chk("beq.c2.stall", int'(stall), 0);
    chk("beq.c2.pc",    int'(pc_mode), 1);
    chk("beq.c2.flush", int'(flush), 0);
    tick();
    idle_inputs();
    settle();
    $display("beq c3: stall=%0d pc=%0d flush=%0d st=%0d", stall, pc_mode, flush, hz_state);
    chk("beq.c3.flush", int'(flush), 1);
    chk("beq.c3.stall", int'(stall), 0);
    chk("beq.c3.state", int'(hz_state), int'(FLUSH));
    tick();
    settle();
    chk("beq.c4.flush", int'(flush), 0);
    chk("beq.c4.state", int'(hz_state), int'(RUN));
    tick();

    // ---- BNE not taken, resolution well past BR_LAT ----
    id_valid = 1; id_opcode = OP_BNE;
    for (int c = 0; c < 6; c++) begin
      settle();
      $display("bne c%0d: stall=%0d flush=%0d st=%0d", c, stall, flush, hz_state);
      chk($sformatf("bne.c%0d.stall", c), int'(stall), 1);
      chk($sformatf("bne.c%0d.flush", c), int'(flush), 0);
      tick();
    end
    br_resolved = 1; br_taken = 0;
    settle();
    $display("bne c6: stall=%0d pc=%0d flush=%0d", stall, pc_mode, flush);
    chk("bne.c6.stall", int'(stall), 0);
    chk("bne.c6.pc",    int'(pc_mode), 0);
    chk("bne.c6.flush", int'(flush), 0);
    tick();
    idle_inputs();
    settle();
    chk("bne.c7.flush", int'(flush), 0);
    chk("bne.c7.state", int'(hz_state), int'(RUN));
    tick();

    // ---- ST blocked by peripherals for 4 cycles ----
    id_valid = 1; id_opcode = OP_ST;
    for (int c = 0; c < 4; c++) begin
      mem_busy = (c % 2 == 0) ? MEM_SPART : MEM_AUDIO;
      settle();
      $display("st c%0d: stall=%0d st=%0d", c, stall, hz_state);
      chk($sformatf("st.c%0d.stall", c), int'(stall), 1);
      tick();
    end
    mem_busy = MEM_IDLE;
    settle();
    $display("st c4: stall=%0d st=%0d", stall, hz_state);
    chk("st.c4.stall", int'(stall), 0);
    chk("st.c4.state", int'(hz_state), int'(MEM_WAIT));
    tick();
    id_valid = 0;
    settle();
    chk("st.c5.state", int'(hz_state), int'(RUN));
    idle_inputs();
    tick();

    // ---- priority: memory wait beats load-use ----
    id_valid = 1; id_opcode = OP_LD; id_src = srcs(3, 0);
    stg_rd = rds(3, 0, 0); stg_wr = 3'b001; ex_is_load = 1; mem_busy = MEM_AUDIO;
    settle();
    chk("prio_mem.stall", int'(stall), 1);
    tick();
    settle();
    $display("prio_mem: st=%0d", hz_state);
    chk("prio_mem.state", int'(hz_state), int'(MEM_WAIT));
    idle_inputs();
    tick();
    tick();

    // ---- priority: branch resolution beats a memory hazard in ID ----
    id_valid = 1; id_opcode = OP_BEQ;
    tick();
    id_opcode = OP_LD; mem_busy = MEM_SPART; br_resolved = 1; br_taken = 1;
    settle();
    $display("prio_br: stall=%0d pc=%0d st=%0d", stall, pc_mode, hz_state);
    chk("prio_br.pc",    int'(pc_mode), 1);
    chk("prio_br.stall", int'(stall), 0);
    tick();
    idle_inputs();
    settle();
    chk("prio_br.next", int'(hz_state), int'(FLUSH));
    tick();
    tick();

    // ---- reset in the middle of BR_WAIT ----
    id_valid = 1; id_opcode = OP_BEQ;
    tick();
    settle();
    chk("rst_br.pre_state", int'(hz_state), int'(BR_WAIT));
    rst_n = 0;
    settle();
    chk("rst_br.during_stall", int'(stall), 0);
    tick();
    rst_n = 1;
    idle_inputs();
    settle();
    $display("rst_br: stall=%0d flush=%0d st=%0d", stall, flush, hz_state);
    chk("rst_br.state", int'(hz_state), int'(RUN));
    chk("rst_br.stall", int'(stall), 0);
    chk("rst_br.flush", int'(flush), 0);
    tick();
    settle();
    chk("rst_br.flush_after", int'(flush), 0);
    tick();

    // ---- randomized run against the reference model ----
    do_reset();
    m_br = 0; m_mem = 0; m_fl = 0; m_ld = 0;
    for (int c = 0; c < 400; c++) begin
      rst_n       = ($urandom_range(0, 49) != 0);
      id_valid    = ($urandom_range(0, 9) < 8);
      case ($urandom_range(0, 7))
        0: id_opcode = OP_ADD;
        1: id_opcode = OP_LD;
        2: id_opcode = OP_ST;
        3: id_opcode = OP_BEQ;
        4: id_opcode = OP_BNE;
        5: id_opcode = OP_JI;
        6: id_opcode = OP_JR;
        default: id_opcode = 6'h3f;
      endcase
      id_src      = srcs($urandom_range(0, 7), $urandom_range(0, 7));
      stg_rd      = rds($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
      stg_wr      = 3'($urandom);
      ex_is_load  = ($urandom_range(0, 2) == 0);
      br_resolved = ($urandom_range(0, 2) == 0);
      br_taken    = 1'($urandom);
      mem_busy    = 2'($urandom);
      model_eval();
      settle();
      $display("rand %0d: rst_n=%0d op=%h vld=%0d stall=%0d flush=%0d pc=%0d fwd=%h st=%0d",
               c, rst_n, id_opcode, id_valid, stall, flush, pc_mode, fwd_sel, hz_state);
      chk_out($sformatf("rand%0d", c), e_stall, e_flush, e_pc, e_fwd, e_state);
      tick();
      model_commit();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
